// File: rtl/frame_buffer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// frame_buffer_controller : double-buffered pixel store with vblank-synchronised
//                           swap and optional clear of the new back bank.
// Revision: 1.0
// ============================================================================
module frame_buffer_controller #(
  parameter int          ADDR_W        = 16,
  parameter bit          CLEAR_ON_SWAP = 1'b1,
  parameter logic [23:0] CLEAR_COLOR   = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fb_wfb,
  input  logic              fb_dfb,
  input  logic [ADDR_W-1:0] fb_px,
  input  logic [7:0]        fb_r,
  input  logic [7:0]        fb_g,
  input  logic [7:0]        fb_b,
  output logic              fb_busy,
  input  logic              vblank,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [23:0]       disp_rgb,
  output logic              wr_dropped
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    SWAP    = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_front_sel;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic [23:0] r_bank0 [DEPTH];
  logic [23:0] r_bank1 [DEPTH];

  logic              w_host_wr;
  logic              w_clr_wr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [23:0]       w_wdata;

  // Both the host and the clear engine target the back bank (the one not shown).
  assign w_host_wr = fb_wfb && !fb_busy;
  assign w_clr_wr  = (r_state == CLEAR);
  assign w_we      = w_host_wr || w_clr_wr;
  assign w_waddr   = w_clr_wr ? r_clr_cnt : fb_px;
  assign w_wdata   = w_clr_wr ? CLEAR_COLOR : {fb_r, fb_g, fb_b};

  always_ff @(posedge clk) begin
    if (w_we && r_front_sel)
      r_bank0[w_waddr] <= w_wdata;
    if (w_we && !r_front_sel)
      r_bank1[w_waddr] <= w_wdata;
  end

  // front_sel only changes at the end of SWAP, so a read in that cycle sees the old front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      disp_rgb <= 24'h000000;
    else if (disp_rd)
      disp_rgb <= r_front_sel ? r_bank1[disp_addr] : r_bank0[disp_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      fb_busy     <= 1'b0;
      r_front_sel <= 1'b0;
      r_clr_cnt   <= '0;
      wr_dropped  <= 1'b0;
    end else begin
      if (fb_busy && (fb_wfb || fb_dfb))
        wr_dropped <= 1'b1;
      case (r_state)
        IDLE: begin
          if (fb_dfb) begin
            r_state <= WAIT_VB;
            fb_busy <= 1'b1;
          end
        end
        WAIT_VB: begin
          if (vblank)
            r_state <= SWAP;
        end
        SWAP: begin
          r_front_sel <= ~r_front_sel;
          if (CLEAR_ON_SWAP) begin
            r_state <= CLEAR;
          end else begin
            r_state <= IDLE;
            fb_busy <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state   <= IDLE;
            fb_busy   <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          fb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_frame_buffer_controller : self-checking bench with a cycle model of the
//                              double-buffered store.
// Revision: 1.0
// ============================================================================
module tb_frame_buffer_controller;

  localparam int          AW = 4;
  localparam int          N  = 16;
  localparam logic [23:0] CC = 24'h0000FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fb_wfb, fb_dfb, vblank, disp_rd;
  logic [AW-1:0] fb_px, disp_addr;
  logic [7:0]    fb_r, fb_g, fb_b;
  wire           fb_busy, wr_dropped;
  wire  [23:0]   disp_rgb;

  logic          a_wfb, a_dfb, a_vb, a_rd;
  logic [15:0]   a_px, a_addr;
  logic [23:0]   a_wrgb;
  wire           a_busy, a_drop;
  wire  [23:0]   a_rgb;

  frame_buffer_controller #(.ADDR_W(AW), .CLEAR_ON_SWAP(1'b1), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst_n(rst_n), .fb_wfb(fb_wfb), .fb_dfb(fb_dfb), .fb_px(fb_px),
    .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b), .fb_busy(fb_busy), .vblank(vblank),
    .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_rgb(disp_rgb), .wr_dropped(wr_dropped)
  );

  frame_buffer_controller #(.ADDR_W(16), .CLEAR_ON_SWAP(1'b0), .CLEAR_COLOR(24'h000000)) dut_w (
    .clk(clk), .rst_n(rst_n), .fb_wfb(a_wfb), .fb_dfb(a_dfb), .fb_px(a_px),
    .fb_r(a_wrgb[23:16]), .fb_g(a_wrgb[15:8]), .fb_b(a_wrgb[7:0]), .fb_busy(a_busy),
    .vblank(a_vb), .disp_rd(a_rd), .disp_addr(a_addr), .disp_rgb(a_rgb), .wr_dropped(a_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending = swap requested but vblank not yet seen; left = busy cycles
  // remaining after vblank (one swap cycle followed by N clear cycles).
  logic [23:0] m_bank  [2][N];
  bit          m_known [2][N];
  bit          m_front = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_rgb_known = 1'b1;
  int          m_left = 0;
  logic [23:0] m_rgb = 24'h0;
  bit          m_busy;
  bit          m_back;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_front = 1'b0; m_pending = 1'b0; m_left = 0;
      m_drop = 1'b0; m_rgb = 24'h0; m_rgb_known = 1'b1;
    end else begin
      m_busy = m_pending || (m_left > 0);
      m_back = ~m_front;
      if (disp_rd) begin
        m_rgb       = m_bank[m_front][disp_addr];
        m_rgb_known = m_known[m_front][disp_addr];
      end
      if (!m_busy) begin
        if (fb_wfb) begin
          m_bank[m_back][fb_px]  = {fb_r, fb_g, fb_b};
          m_known[m_back][fb_px] = 1'b1;
        end
        if (fb_dfb) m_pending = 1'b1;
      end else begin
        if (fb_wfb || fb_dfb) m_drop = 1'b1;
        if (m_pending) begin
          if (vblank) begin
            m_pending = 1'b0;
            m_left    = 1 + N;
          end
        end else begin
          if (m_left == 1 + N) begin
            m_front = ~m_front;
          end else begin
            m_bank[m_back][N - m_left]  = CC;
            m_known[m_back][N - m_left] = 1'b1;
          end
          m_left--;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("fb_busy", {23'b0, fb_busy}, {23'b0, (m_pending || (m_left > 0))});
    chk("wr_dropped", {23'b0, wr_dropped}, {23'b0, m_drop});
    if (m_rgb_known) chk("disp_rgb", disp_rgb, m_rgb);
  end

  function automatic logic [23:0] fill(input int a);
    return 24'h102030 + 24'(a) * 24'h010101;
  endfunction

  task automatic step(input bit wfb, input bit dfb, input logic [AW-1:0] px,
                      input logic [23:0] rgb, input bit vb, input bit rd,
                      input logic [AW-1:0] ra);
    fb_wfb = wfb; fb_dfb = dfb; fb_px = px;
    fb_r = rgb[23:16]; fb_g = rgb[15:8]; fb_b = rgb[7:0];
    vblank = vb; disp_rd = rd; disp_addr = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 24'h0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, 24'h0, 1'b0, 1'b1, a);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (fb_busy && cycles < 60) begin
      idle();
      cycles++;
    end
    chk("busy_bound", {23'b0, fb_busy}, 24'h0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    fb_wfb = 0; fb_dfb = 0; fb_px = '0; fb_r = 0; fb_g = 0; fb_b = 0;
    vblank = 0; disp_rd = 0; disp_addr = '0;
    a_wfb = 0; a_dfb = 0; a_vb = 0; a_rd = 0; a_px = '0; a_addr = '0; a_wrgb = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {23'b0, fb_busy}, 24'h0);
    chk("reset_rgb", disp_rgb, 24'h0);
    chk("reset_drop", {23'b0, wr_dropped}, 24'h0);
    rst_n = 1'b1;

    // Full-width instance: write, swap with vblank already high, read back.
    a_wfb = 1; a_px = 16'h1234; a_wrgb = 24'hFF8000;
    @(negedge clk);
    a_wfb = 0; a_dfb = 1;
    @(negedge clk);
    a_dfb = 0;
    chk("w_busy_after_dfb", {23'b0, a_busy}, 24'h1);
    a_vb = 1;
    @(negedge clk);
    a_vb = 0;
    @(negedge clk);
    chk("w_busy_after_swap", {23'b0, a_busy}, 24'h0);
    a_rd = 1; a_addr = 16'h1234;
    @(negedge clk);
    a_rd = 0;
    chk("w_read_1234", a_rgb, 24'hFF8000);
    chk("w_drop", {23'b0, a_drop}, 24'h0);

    // Fill the back bank, then swap and time the busy window.
    for (int a = 0; a < N; a++) step(1'b1, 1'b0, AW'(a), fill(a), 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0, 24'h0, 1'b0, 1'b0, '0);
    chk("busy_after_dfb", {23'b0, fb_busy}, 24'h1);
    step(1'b0, 1'b0, '0, 24'h0, 1'b1, 1'b0, '0);
    n = 0;
    while (fb_busy && n < 60) begin
      idle();
      n++;
    end
    chk("busy_len_after_vblank", 24'(n), 24'd17);
    rd(4'd5);
    chk("read_filled_5", disp_rgb, 24'h152535);

    // Long wait for vblank: busy stays high, front bank unchanged.
    step(1'b0, 1'b1, '0, 24'h0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      rd(4'd2);
      chk("busy_wait_vb", {23'b0, fb_busy}, 24'h1);
      chk("front_held", disp_rgb, 24'h122232);
    end
    step(1'b0, 1'b0, '0, 24'h0, 1'b1, 1'b0, '0);
    rd(4'd2);
    chk("swap_cycle_read", disp_rgb, 24'h122232);
    rd(4'd2);
    chk("post_swap_read", disp_rgb, CC);
    step(1'b1, 1'b0, 4'd5, 24'h123456, 1'b0, 1'b0, '0);
    chk("drop_in_clear", {23'b0, wr_dropped}, 24'h1);
    wait_idle(n);
    for (int a = 0; a < N; a++) begin
      rd(AW'(a));
      chk("cleared_bank", disp_rgb, CC);
    end

    // Write and draw request in the same idle cycle.
    step(1'b1, 1'b1, 4'd9, 24'hABCDEF, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 24'h0, 1'b1, 1'b0, '0);
    wait_idle(n);
    rd(4'd9);
    chk("wfb_dfb_same_cycle", disp_rgb, 24'hABCDEF);

    // Asynchronous reset in the middle of a clear (counter at 7).
    step(1'b0, 1'b1, '0, 24'h0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 24'h0, 1'b1, 1'b0, '0);
    repeat (8) idle();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {23'b0, fb_busy}, 24'h0);
    chk("abort_drop", {23'b0, wr_dropped}, 24'h0);
    chk("abort_rgb", disp_rgb, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd3, 24'h445566, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0, 24'h0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 24'h0, 1'b1, 1'b0, '0);
    wait_idle(n);
    rd(4'd3);
    chk("post_reset_write", disp_rgb, 24'h445566);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buffer_controller.md
FRAME_BUFFER_CONTROLLER -- requirements
Module: frame_buffer_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, pixel address width; 2**ADDR_W pixels per bank.
REQ-002 SHALL have parameter CLEAR_ON_SWAP, default 1; 1 = clear new back bank after swap.
REQ-003 SHALL have parameter CLEAR_COLOR, default 24'h000000; {r,g,b} written during clear.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port fb_wfb  input  1  pixel write strobe from sprite command stage.
REQ-007 SHALL have port fb_dfb  input  1  single-cycle draw-frame request (swap buffers).
REQ-008 SHALL have port fb_px  input  ADDR_W  pixel address {x,y} into back bank.
REQ-009 SHALL have ports fb_r, fb_g, fb_b  input  8 each  pixel colour for fb_wfb.
REQ-010 SHALL have port fb_busy  output  1  high while swap/clear in progress.
REQ-011 SHALL have port vblank  input  1  high during display vertical blanking.
REQ-012 SHALL have port disp_rd  input  1  display read strobe.
REQ-013 SHALL have port disp_addr  input  ADDR_W  display read address into front bank.
REQ-014 SHALL have port disp_rgb  output  24  {r,g,b} read data from front bank.
REQ-015 SHALL have port wr_dropped  output  1  sticky: a write or dfb arrived while busy.

Function
REQ-016 SHALL contain two internal banks, each 2**ADDR_W x 24 bits; front_sel selects the display (front) bank, other bank is back.
REQ-017 SHALL, when fb_wfb=1 and fb_busy=0, write {fb_r,fb_g,fb_b} to back[fb_px] at that clock edge.
REQ-018 SHALL, when disp_rd=1, register front[disp_addr] onto disp_rgb one cycle later; disp_rgb holds its value when disp_rd=0.
REQ-019 SHALL use fb_px and disp_addr unmodified; no arithmetic, no bounds check (full address space valid).
REQ-020 SHALL implement states IDLE, WAIT_VB, SWAP, CLEAR.
REQ-021 SHALL, in IDLE with fb_dfb=1, go to WAIT_VB and assert fb_busy (registered) from the next cycle.
REQ-022 SHALL, in WAIT_VB, remain until vblank=1 is sampled, then go to SWAP; vblank already high on entry moves to SWAP on the first WAIT_VB cycle.
REQ-023 SHALL, in SWAP (one cycle), toggle front_sel; next state CLEAR if CLEAR_ON_SWAP=1, else IDLE.
REQ-024 SHALL, in CLEAR, write CLEAR_COLOR to new back bank at counter addresses 0..2**ADDR_W-1, one per cycle, then go to IDLE.
REQ-025 SHALL hold fb_busy=1 in WAIT_VB, SWAP and CLEAR, and 0 in IDLE; fb_busy falls on the cycle state returns to IDLE.
REQ-026 SHALL, with fb_wfb and fb_dfb both high in IDLE, perform the write and then begin the swap.
REQ-027 SHALL ignore fb_wfb and fb_dfb while fb_busy=1, and set wr_dropped=1 for each such event.
REQ-028 SHALL, for a display read in the SWAP cycle, return data from the pre-swap front bank.
REQ-029 SHALL keep display reads from front bank fully functional in all states (no stall).
REQ-030 SHALL use a clear counter of ADDR_W bits that terminates at all-ones without wrap-around re-entry.

Reset
REQ-031 SHALL, on rst_n=0 (any time, including mid-swap or mid-clear), go immediately to IDLE with fb_busy=0, front_sel=0, disp_rgb=0, wr_dropped=0, clear counter=0.
REQ-032 SHALL leave bank contents unchanged and undefined by reset; rst_n aborting CLEAR leaves the bank partially cleared.
REQ-033 SHALL resume normal operation on the first clock edge after rst_n deasserts.

Verification
REQ-034 SHALL cover: write px=16'h1234 rgb=24'hFF8000, dfb, vblank=1 -> after swap, disp_rd addr 16'h1234 returns 24'hFF8000 one cycle later.
REQ-035 SHALL cover: dfb with vblank=0 for 10 cycles -> fb_busy high from cycle after dfb for all 10 cycles, front_sel unchanged until vblank=1.
REQ-036 SHALL cover: ADDR_W=4, CLEAR_ON_SWAP=1, CLEAR_COLOR=24'h0000FF -> fb_busy for exactly 1 (SWAP) + 16 (CLEAR) cycles after vblank sampled; all 16 new back addresses read 24'h0000FF after next swap.
REQ-037 SHALL cover: fb_wfb px=5 during CLEAR -> write discarded, wr_dropped=1; wfb+dfb same IDLE cycle -> write present after swap.
REQ-038 SHALL cover: rst_n low during CLEAR at count 7 -> fb_busy=0, front_sel=0, wr_dropped=0 next cycle; new write accepted to bank 1.
REQ-039 SHALL cover: disp_rd in SWAP cycle -> returns old front bank data; read one cycle later returns new front data.
